// File: rtl/dsm_pkg.sv
// Shared constants for the delta-sigma interpolator / decimator pair.
// Both directions use the same rate ratio and word width.
package dsm_pkg;

    localparam int DSM_DECIM = 50;
    localparam int DSM_W     = 20;
    localparam int CIC_ORDER = 3;
    localparam int CIC_GAIN  = DSM_DECIM * DSM_DECIM * DSM_DECIM;

endpackage

// File: rtl/cic_integ.sv
// One CIC integrator stage: a W-bit accumulator that wraps modulo 2^W.
// Wrapping is intended; the comb section cancels it exactly.
module cic_integ
    import dsm_pkg::*;
#(
    parameter int W = DSM_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    // accumulate while enabled, clear on reset
    always_ff @(posedge clock) begin
        if (reset)
            acc <= '0;
        else if (en)
            acc <= acc + din;
    end

endmodule

// File: rtl/decim_cic.sv
// Third-order CIC decimator: 1-bit modulator stream in, W-bit signed
// PCM out at 1/DECIM of the clock rate, differential delay of one.
module decim_cic
    import dsm_pkg::*;
#(
    parameter int DECIM = DSM_DECIM,
    parameter int W     = DSM_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    localparam int CW = $clog2(DECIM);

    logic [W-1:0]  x;
    logic [W-1:0]  i1;
    logic [W-1:0]  i2;
    logic [W-1:0]  i3;
    logic [W-1:0]  d1;
    logic [W-1:0]  d2;
    logic [W-1:0]  d3;
    logic [W-1:0]  c1;
    logic [W-1:0]  c2;
    logic [W-1:0]  c3;
    logic [CW-1:0] cnt;
    logic          tick;

    // 1 -> +1, 0 -> -1 (all ones)
    assign x = bit_in ? W'(1) : '1;

    cic_integ #(.W(W)) u_i1 (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .din   (x),
        .acc   (i1)
    );

    cic_integ #(.W(W)) u_i2 (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .din   (i1),
        .acc   (i2)
    );

    cic_integ #(.W(W)) u_i3 (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .din   (i2),
        .acc   (i3)
    );

    assign tick = en && (cnt == CW'(DECIM - 1));

    // decimation phase counter, frozen while en is low
    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    // comb differences on the pre-edge integrator output
    always_comb begin
        c1 = i3 - d1;
        c2 = c1 - d2;
        c3 = c2 - d3;
    end

    // comb delays and output register advance once per output sample
    always_ff @(posedge clock) begin
        if (reset) begin
            d1   <= '0;
            d2   <= '0;
            d3   <= '0;
            dout <= '0;
        end else if (tick) begin
            d1   <= i3;
            d2   <= c1;
            d3   <= c2;
            dout <= c3;
        end
    end

    // strobe is the tick delayed by one cycle, aligned with the new dout
    always_ff @(posedge clock) begin
        if (reset)
            dout_valid <= 1'b0;
        else
            dout_valid <= tick;
    end

endmodule

// File: tb/tb_decim_cic.sv
// Self-checking bench for decim_cic: a stimulus-side model queues each
// expected output strobe, the sampler pops and compares it.
module tb_decim_cic;
    import dsm_pkg::*;

    localparam int R = DSM_DECIM;

    typedef enum int { M_ONES, M_ZEROS, M_ALT } mode_t;

    typedef struct {
        int edge_n;
        int val;
        bit chk_val;
        int gap;
        bit from_rst;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             bit_in = 1'b0;
    logic [DSM_W-1:0] dout;
    logic             dout_valid;

    exp_t  q[$];
    int    total = 0;
    int    bad = 0;
    int    edge_n = 0;
    int    ecnt = 0;
    int    frame = 0;
    int    idle = 0;
    int    last_strobe = 0;
    int    rst_edge = 0;
    int    last_dout = 0;
    int    quiet = 0;
    bit    first = 1'b1;
    mode_t mode = M_ONES;

    always #5 clock = ~clock;

    decim_cic dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .bit_in     (bit_in),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (edge %0d)",
                     tag, got, want, edge_n);
        end
    endtask

    // hand-derived CIC outputs for strobe f after reset
    function automatic int exp_val(input mode_t m, input int f);
        int v;
        case (f)
            1:       v = 18424;
            2:       v = 101577;
            3:       v = 124999;
            default: v = CIC_GAIN;
        endcase
        case (m)
            M_ONES:  return v;
            M_ZEROS: return -v;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_chk(input mode_t m, input int f);
        return (m != M_ALT) || (f >= 4);
    endfunction

    task automatic step(input logic r, input logic e, input logic b);
        exp_t x;
        int   sd;
        reset  = r;
        en     = e;
        bit_in = b;
        if (r) begin
            ecnt      = 0;
            frame     = 0;
            idle      = 0;
            first     = 1'b1;
            rst_edge  = edge_n + 1;
            last_dout = 0;
        end else if (e) begin
            if (ecnt == R - 1) begin
                frame++;
                x.edge_n   = edge_n + 1;
                x.val      = exp_val(mode, frame);
                x.chk_val  = exp_chk(mode, frame);
                x.gap      = first ? R + 1 + idle : R + idle;
                x.from_rst = first;
                q.push_back(x);
                ecnt  = 0;
                idle  = 0;
                first = 1'b0;
            end else begin
                ecnt++;
            end
        end else begin
            idle++;
        end
        @(posedge clock);
        edge_n++;
        @(negedge clock);
        sd = $signed(dout);
        if (quiet > 0) begin
            check("quiet_dout", sd, 0);
            check("quiet_valid", int'(dout_valid), 0);
            quiet--;
        end
        if (q.size() > 0 && q[0].edge_n == edge_n) begin
            x = q.pop_front();
            check("strobe", int'(dout_valid), 1);
            if (x.from_rst)
                check("first_pos", edge_n - rst_edge + 1, x.gap);
            else
                check("gap", edge_n - last_strobe, x.gap);
            last_strobe = edge_n;
            if (x.chk_val)
                check("dout", sd, x.val);
            last_dout = sd;
        end else begin
            check("no_strobe", int'(dout_valid), 0);
            check("hold", sd, last_dout);
        end
    endtask

    task automatic do_reset(input int n, input logic e, input logic b);
        for (int i = 0; i < n; i++)
            step(1'b1, e, b);
    endtask

    initial begin
        int   g;
        logic b;

        // reset with live input, then all-ones stream
        mode  = M_ONES;
        quiet = 5 + (R - 1);
        do_reset(5, 1'b1, 1'b1);
        while (frame < 6)
            step(1'b0, 1'b1, 1'b1);

        // all-zeros stream
        mode = M_ZEROS;
        do_reset(2, 1'b1, 1'b0);
        while (frame < 6)
            step(1'b0, 1'b1, 1'b0);

        // all-ones with en low for 17 cycles inside the second frame
        mode = M_ONES;
        do_reset(2, 1'b1, 1'b1);
        g = 0;
        while (frame < 6) begin
            if (frame == 1 && ecnt == 20 && g < 17) begin
                step(1'b0, 1'b0, 1'b1);
                g++;
            end else begin
                step(1'b0, 1'b1, 1'b1);
            end
        end

        // one-cycle reset at cnt=30 in the fifth frame
        mode = M_ONES;
        do_reset(2, 1'b1, 1'b1);
        while (!(frame == 4 && ecnt == 30))
            step(1'b0, 1'b1, 1'b1);
        quiet = 1;
        step(1'b1, 1'b1, 1'b1);
        while (frame < 6)
            step(1'b0, 1'b1, 1'b1);

        // alternating stream, long enough for the integrators to wrap
        mode = M_ALT;
        do_reset(2, 1'b1, 1'b1);
        b = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            step(1'b0, 1'b1, b);
            b = ~b;
        end

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
